// File: rtl/fc_stream_io.sv
// Streaming front/back end for the fully-connected layer: packs a serial element
// stream into the layer input vector, starts the layer, and serialises its result.
module fc_stream_io #(
  parameter int IN_SIZE  = 256,
  parameter int OUT_SIZE = 8,
  parameter int W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W-1:0]          s_data,
  input  logic                  s_last,
  output logic [W*IN_SIZE-1:0]  in_vector_flat,
  output logic                  start,
  input  logic                  layer_done,
  input  logic [W*OUT_SIZE-1:0] out_vector_flat,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [W-1:0]          m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_len
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_SIZE - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_SIZE - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         in_idx;
  logic [OW-1:0]         out_idx;
  logic [OW-1:0]         out_nx;
  logic                  done_q;
  logic [W*OUT_SIZE-1:0] snapshot;
  logic                  accept, frame_end, capture, m_fire, drain_end;

  assign s_ready   = (state == LOAD);
  assign busy      = (state != LOAD);
  assign accept    = s_valid && s_ready;
  assign frame_end = accept && (s_last || (in_idx == IN_LAST));
  // done_q samples every cycle, so a level still high from before START is not an edge
  assign capture   = (state == WAIT) && layer_done && !done_q;
  assign m_fire    = (state == DRAIN) && m_valid && m_ready;
  assign drain_end = m_fire && (out_idx == OUT_LAST);
  assign out_nx    = out_idx + OW'(1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (frame_end) state_nx = START; else state_nx = LOAD;
      START:   state_nx = WAIT;
      WAIT:    if (capture) state_nx = DRAIN; else state_nx = WAIT;
      DRAIN:   if (drain_end) state_nx = LOAD; else state_nx = DRAIN;
      default: state_nx = LOAD;
    endcase
  end

  // input packing, start pulse and sticky length error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_idx         <= '0;
      in_vector_flat <= '0;
      start          <= 1'b0;
      err_len        <= 1'b0;
    end else begin
      start <= frame_end;
      if (accept) begin
        // an early s_last zero-fills the tail so the layer never sees stale elements
        for (int i = 0; i < IN_SIZE; i++) begin
          if (i == int'(in_idx)) begin
            in_vector_flat[i*W +: W] <= s_data;
          end else if (s_last && (i > int'(in_idx))) begin
            in_vector_flat[i*W +: W] <= '0;
          end
        end
        in_idx <= frame_end ? '0 : in_idx + IW'(1);
        if (s_last != (in_idx == IN_LAST)) begin
          err_len <= 1'b1;
        end
      end
    end
  end

  // result capture and output serialiser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      snapshot <= '0;
      out_idx  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      done_q <= layer_done;
      if (capture) begin
        snapshot <= out_vector_flat;
        out_idx  <= '0;
        m_valid  <= 1'b1;
        m_data   <= out_vector_flat[0 +: W];
        m_last   <= (OUT_SIZE == 1);
      end else if (m_fire) begin
        if (drain_end) begin
          out_idx <= '0;
          m_valid <= 1'b0;
          m_data  <= '0;
          m_last  <= 1'b0;
        end else begin
          out_idx <= out_nx;
          m_data  <= snapshot[int'(out_nx)*W +: W];
          m_last  <= (out_nx == OUT_LAST);
        end
      end
    end
  end

endmodule
